// File: rtl/i2s_tx_pkg.sv
// rtl/i2s_tx_pkg.sv - shared types and helpers for the I2S transmitter
package i2s_tx_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic WS_LEFT  = 1'b0;
    localparam logic WS_RIGHT = 1'b1;

    // WS leads each channel by one bit: right is selected from the left LSB
    // slot up to the bit before the right LSB.
    function automatic logic ws_for_pos(input int unsigned pos, input int unsigned word_w);
        return ((pos >= word_w - 1) && (pos <= 2 * word_w - 2)) ? WS_RIGHT : WS_LEFT;
    endfunction

endpackage

// File: rtl/i2s_tx_fifo.sv
// rtl/i2s_tx_fifo.sv - synchronous frame FIFO with combinational head read
module i2s_tx_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // Extra pointer bit separates the full and empty cases when indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    // Storage write; contents need no reset because the pointers gate reads.
    always_ff @(posedge clk_i) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    // Pointer update; flags derive from registered pointers only, so no bypass.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2s_tx_master.sv
// rtl/i2s_tx_master.sv - Philips I2S transmitter and bit/word clock master
module i2s_tx_master
    import i2s_tx_pkg::*;
#(
    parameter int unsigned WORD_W     = 16,
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic [WORD_W-1:0] sample_l_i,
    input  logic [WORD_W-1:0] sample_r_i,
    input  logic              sample_valid_i,
    output logic              sample_ready_o,
    output logic              i2s_sck_o,
    output logic              i2s_ws_o,
    output logic              i2s_sd_o,
    output logic              underrun_o,
    output logic              busy_o
);

    localparam int unsigned FRAME_W = 2 * WORD_W;
    localparam int unsigned POS_W   = $clog2(FRAME_W);
    localparam int unsigned DIV_W   = $clog2(CLK_DIV);

    localparam logic [POS_W-1:0] POS_LAST = POS_W'(FRAME_W - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    // Left sample occupies the upper half so it leaves the shifter first.
    typedef struct packed {
        logic [WORD_W-1:0] l;
        logic [WORD_W-1:0] r;
    } frame_t;

    frame_t fifo_in;
    frame_t fifo_head;
    logic   fifo_push;
    logic   fifo_pop;
    logic   fifo_full;
    logic   fifo_empty;

    state_t             state_q,    state_n;
    logic [DIV_W-1:0]   div_cnt_q,  div_cnt_n;
    logic [POS_W-1:0]   pos_q,      pos_n;
    logic [FRAME_W-1:0] shreg_q,    shreg_n;
    logic               sck_q,      sck_n;
    logic               ws_q,       ws_n;
    logic               busy_q,     busy_n;
    logic               underrun_q, underrun_n;
    logic               load;
    logic [FRAME_W-1:0] load_word;

    assign fifo_in   = '{l: sample_l_i, r: sample_r_i};
    assign fifo_push = sample_valid_i && !fifo_full;
    assign fifo_pop  = load && !fifo_empty;
    assign load_word = fifo_empty ? '0 : fifo_head;

    i2s_tx_fifo #(
        .WIDTH (FRAME_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (fifo_in),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Next-state: divider, SCK toggle, shift/pos on falling SCK, frame reload or stop.
    always_comb begin
        state_n    = state_q;
        div_cnt_n  = div_cnt_q;
        pos_n      = pos_q;
        shreg_n    = shreg_q;
        sck_n      = sck_q;
        busy_n     = busy_q;
        underrun_n = 1'b0;
        load       = 1'b0;

        case (state_q)
            IDLE: begin
                if (en_i) begin
                    load       = 1'b1;
                    state_n    = RUN;
                    div_cnt_n  = '0;
                    sck_n      = 1'b0;
                    pos_n      = '0;
                    shreg_n    = load_word;
                    busy_n     = 1'b1;
                    underrun_n = fifo_empty;
                end
            end
            RUN: begin
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_n = '0;
                    sck_n     = !sck_q;
                    if (sck_q) begin
                        if (pos_q == POS_LAST) begin
                            pos_n = '0;
                            if (en_i) begin
                                load       = 1'b1;
                                shreg_n    = load_word;
                                underrun_n = fifo_empty;
                            end else begin
                                state_n = IDLE;
                                shreg_n = '0;
                                busy_n  = 1'b0;
                            end
                        end else begin
                            pos_n   = pos_q + 1'b1;
                            shreg_n = {shreg_q[FRAME_W-2:0], 1'b0};
                        end
                    end
                end else begin
                    div_cnt_n = div_cnt_q + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        // pos is held at zero outside RUN, which also yields WS_LEFT in IDLE.
        ws_n = ws_for_pos(32'(pos_n), WORD_W);
    end

    // State register; reset discards any partial frame.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            div_cnt_q  <= '0;
            pos_q      <= '0;
            shreg_q    <= '0;
            sck_q      <= 1'b0;
            ws_q       <= WS_LEFT;
            busy_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_n;
            div_cnt_q  <= div_cnt_n;
            pos_q      <= pos_n;
            shreg_q    <= shreg_n;
            sck_q      <= sck_n;
            ws_q       <= ws_n;
            busy_q     <= busy_n;
            underrun_q <= underrun_n;
        end
    end

    assign sample_ready_o = !fifo_full;
    assign i2s_sck_o      = sck_q;
    assign i2s_ws_o       = ws_q;
    assign i2s_sd_o       = shreg_q[FRAME_W-1];
    assign underrun_o     = underrun_q;
    assign busy_o         = busy_q;

endmodule

// File: tb/tb_i2s_tx_master.sv
// tb/tb_i2s_tx_master.sv - directed self-checking bench for i2s_tx_master
module tb_i2s_tx_master;

    logic clk = 1'b0;

    logic        rst = 1'b1, en = 1'b0, valid = 1'b0;
    logic [15:0] l1 = '0, r1 = '0;
    logic        ready, sck, ws, sd, und, busy;

    logic        rst2 = 1'b1, en2 = 1'b0, valid2 = 1'b0;
    logic [31:0] l2 = '0, r2 = '0;
    logic        ready2, sck2, ws2, sd2, und2, busy2;

    int checks = 0;
    int errors = 0;

    logic [63:0] rx1_q[$], ws1_q[$], rx2_q[$], ws2_q[$];
    logic [63:0] sh1 = '0, wsh1 = '0, sh2 = '0, wsh2 = '0;
    int bit1 = 0, bit2 = 0, und1 = 0, und2c = 0, busy1_cyc = 0;
    int gapbad1 = 0, gapbad2 = 0, last1 = -1, last2 = -1, mcyc = 0;
    logic psck1 = 1'b0, psck2 = 1'b0;

    i2s_tx_master #(.WORD_W(16), .CLK_DIV(4), .FIFO_DEPTH(4)) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en),
        .sample_l_i(l1), .sample_r_i(r1), .sample_valid_i(valid), .sample_ready_o(ready),
        .i2s_sck_o(sck), .i2s_ws_o(ws), .i2s_sd_o(sd), .underrun_o(und), .busy_o(busy)
    );

    i2s_tx_master #(.WORD_W(32), .CLK_DIV(2), .FIFO_DEPTH(4)) dut_wide (
        .clk_i(clk), .rst_i(rst2), .en_i(en2),
        .sample_l_i(l2), .sample_r_i(r2), .sample_valid_i(valid2), .sample_ready_o(ready2),
        .i2s_sck_o(sck2), .i2s_ws_o(ws2), .i2s_sd_o(sd2), .underrun_o(und2), .busy_o(busy2)
    );

    always #5 clk = !clk;

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Bench I2S receiver: samples SD/WS on SCK rise, frames counted from busy rise.
    initial begin : receiver
        forever begin
            @(negedge clk);
            if (und) und1++;
            if (und2) und2c++;
            if (busy) busy1_cyc++;
            if (!busy) begin
                bit1 = 0; sh1 = '0; wsh1 = '0; last1 = -1;
            end else if (sck && !psck1) begin
                sh1 = {sh1[62:0], sd}; wsh1 = {wsh1[62:0], ws}; bit1++;
                if (last1 >= 0 && mcyc - last1 != 8) gapbad1++;
                last1 = mcyc;
                if (bit1 == 32) begin
                    rx1_q.push_back(sh1); ws1_q.push_back(wsh1);
                    bit1 = 0; sh1 = '0; wsh1 = '0;
                end
            end
            psck1 = sck;
            if (!busy2) begin
                bit2 = 0; sh2 = '0; wsh2 = '0; last2 = -1;
            end else if (sck2 && !psck2) begin
                sh2 = {sh2[62:0], sd2}; wsh2 = {wsh2[62:0], ws2}; bit2++;
                if (last2 >= 0 && mcyc - last2 != 4) gapbad2++;
                last2 = mcyc;
                if (bit2 == 64) begin
                    rx2_q.push_back(sh2); ws2_q.push_back(wsh2);
                    bit2 = 0; sh2 = '0; wsh2 = '0;
                end
            end
            psck2 = sck2;
            mcyc++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push1(input logic [15:0] l, input logic [15:0] r);
        int n;
        l1 = l; r1 = r; valid = 1'b1; n = 0;
        while (!ready && n < 3000) begin tick(1); n++; end
        if (n >= 3000) begin checks++; errors++; $display("FAIL push1_timeout: ready stuck low"); end
        tick(1);
        valid = 1'b0;
    endtask

    task automatic push2(input logic [31:0] l, input logic [31:0] r);
        int n;
        l2 = l; r2 = r; valid2 = 1'b1; n = 0;
        while (!ready2 && n < 3000) begin tick(1); n++; end
        if (n >= 3000) begin checks++; errors++; $display("FAIL push2_timeout: ready stuck low"); end
        tick(1);
        valid2 = 1'b0;
    endtask

    task automatic wait_rx1(input int count);
        int n;
        n = 0;
        while (rx1_q.size() < count && n < 4000) begin tick(1); n++; end
        if (n >= 4000) begin checks++; errors++; $display("FAIL wait_rx1: got %0d frames, need %0d", rx1_q.size(), count); end
    endtask

    task automatic wait_rx2(input int count);
        int n;
        n = 0;
        while (rx2_q.size() < count && n < 8000) begin tick(1); n++; end
        if (n >= 8000) begin checks++; errors++; $display("FAIL wait_rx2: got %0d frames, need %0d", rx2_q.size(), count); end
    endtask

    task automatic wait_idle1();
        int n;
        n = 0;
        while (busy && n < 4000) begin tick(1); n++; end
        if (n >= 4000) begin checks++; errors++; $display("FAIL wait_idle1: busy stuck high"); end
    endtask

    task automatic test_reset();
        rst = 1'b1; rst2 = 1'b1;
        tick(3);
        rst = 1'b0; rst2 = 1'b0;
        checks++; if (sck !== 1'b0) begin errors++; $display("FAIL reset_sck: got %b expected 0", sck); end
        checks++; if (ws !== 1'b0) begin errors++; $display("FAIL reset_ws: got %b expected 0", ws); end
        checks++; if (sd !== 1'b0) begin errors++; $display("FAIL reset_sd: got %b expected 0", sd); end
        checks++; if (und !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %b expected 0", und); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready); end
        checks++; if ({ready2, busy2, sck2} !== 3'b100) begin errors++; $display("FAIL reset_wide: got %b expected 100", {ready2, busy2, sck2}); end
    endtask

    task automatic test_basic_frame();
        int base, ub, bb, gb, n;
        base = rx1_q.size(); ub = und1; bb = busy1_cyc; gb = gapbad1;
        push1(16'hA5F0, 16'h0F0F);
        en = 1'b1;
        tick(1);
        en = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL start_busy: got %b expected 1", busy); end
        checks++; if (sd !== 1'b1) begin errors++; $display("FAIL start_sd_msb: got %b expected 1", sd); end
        n = 0;
        while (!sck && n < 50) begin tick(1); n++; end
        checks++; if (n !== 4) begin errors++; $display("FAIL first_rise_delay: got %0d expected 4", n); end
        wait_rx1(base + 1);
        wait_idle1();
        checks++; if (rx1_q[base] !== 64'h0000_0000_A5F0_0F0F) begin errors++; $display("FAIL basic_data: got %h expected a5f00f0f", rx1_q[base]); end
        checks++; if (ws1_q[base] !== 64'h0000_0000_0001_FFFE) begin errors++; $display("FAIL basic_ws_pattern: got %h expected 0001fffe", ws1_q[base]); end
        checks++; if (gapbad1 - gb !== 0) begin errors++; $display("FAIL basic_sck_period: got %0d bad periods expected 0", gapbad1 - gb); end
        checks++; if (busy1_cyc - bb !== 256) begin errors++; $display("FAIL basic_frame_len: got %0d expected 256", busy1_cyc - bb); end
        checks++; if (und1 - ub !== 0) begin errors++; $display("FAIL basic_underrun: got %0d expected 0", und1 - ub); end
    endtask

    task automatic test_underrun();
        int base, ub;
        base = rx1_q.size(); ub = und1;
        en = 1'b1;
        wait_rx1(base + 2);
        checks++; if (und1 - ub !== 2) begin errors++; $display("FAIL underrun_pulses: got %0d expected 2", und1 - ub); end
        push1(16'h1234, 16'h5678);
        tick(8);
        en = 1'b0;
        wait_rx1(base + 3);
        wait_idle1();
        checks++; if (rx1_q[base] !== 64'h0) begin errors++; $display("FAIL underrun_frame0: got %h expected 0", rx1_q[base]); end
        checks++; if (rx1_q[base+1] !== 64'h0) begin errors++; $display("FAIL underrun_frame1: got %h expected 0", rx1_q[base+1]); end
        checks++; if (rx1_q[base+2] !== 64'h0000_0000_1234_5678) begin errors++; $display("FAIL underrun_recover: got %h expected 12345678", rx1_q[base+2]); end
        checks++; if (und1 - ub !== 2) begin errors++; $display("FAIL underrun_no_extra: got %0d expected 2", und1 - ub); end
    endtask

    task automatic test_backpressure();
        logic [31:0] bp [5];
        int base, ub, acc, n;
        bp[0] = 32'h1111_2222; bp[1] = 32'h3333_4444; bp[2] = 32'h5555_6666;
        bp[3] = 32'h7777_8888; bp[4] = 32'h9999_AAAA;
        base = rx1_q.size(); ub = und1;
        valid = 1'b1; acc = 0; n = 0;
        while (acc < 4 && n < 50) begin
            {l1, r1} = bp[acc];
            if (ready) acc++;
            tick(1);
            n++;
        end
        {l1, r1} = bp[4];
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full: got %b expected 0", ready); end
        tick(2);
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL bp_ready_held: got %b expected 0", ready); end
        en = 1'b1;
        tick(1);
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after_pop: got %b expected 1", ready); end
        tick(1);
        valid = 1'b0;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL bp_fifth_accepted: got ready %b expected 0", ready); end
        wait_rx1(base + 4);
        tick(8);
        en = 1'b0;
        wait_rx1(base + 5);
        wait_idle1();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rx1_q[base+i] !== {32'h0, bp[i]}) begin errors++; $display("FAIL bp_order_%0d: got %h expected %h", i, rx1_q[base+i], bp[i]); end
        end
        checks++; if (und1 - ub !== 0) begin errors++; $display("FAIL bp_underrun: got %0d expected 0", und1 - ub); end
    endtask

    task automatic test_disable_mid_frame();
        int base, ub, n, bad;
        base = rx1_q.size(); ub = und1;
        push1(16'hDEAD, 16'hBEEF);
        push1(16'h0123, 16'h4567);
        push1(16'h89AB, 16'hCDEF);
        en = 1'b1;
        n = 0;
        while (bit1 < 11 && n < 500) begin tick(1); n++; end
        en = 1'b0;
        wait_rx1(base + 1);
        wait_idle1();
        checks++; if (rx1_q[base] !== 64'h0000_0000_DEAD_BEEF) begin errors++; $display("FAIL dis_frame: got %h expected deadbeef", rx1_q[base]); end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if ({sck, ws, sd, busy} !== 4'b0000) bad++;
            tick(1);
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL dis_idle_outputs: got %0d nonzero cycles expected 0", bad); end
        en = 1'b1;
        wait_rx1(base + 2);
        tick(8);
        en = 1'b0;
        wait_rx1(base + 3);
        wait_idle1();
        checks++; if (rx1_q[base+1] !== 64'h0000_0000_0123_4567) begin errors++; $display("FAIL dis_resume0: got %h expected 01234567", rx1_q[base+1]); end
        checks++; if (rx1_q[base+2] !== 64'h0000_0000_89AB_CDEF) begin errors++; $display("FAIL dis_resume1: got %h expected 89abcdef", rx1_q[base+2]); end
        checks++; if (und1 - ub !== 0) begin errors++; $display("FAIL dis_underrun: got %0d expected 0", und1 - ub); end
    endtask

    task automatic test_reset_mid_frame();
        int base, ub, n;
        base = rx1_q.size();
        push1(16'h1357, 16'h2468);
        push1(16'h9BDF, 16'hACE0);
        en = 1'b1;
        n = 0;
        while (bit1 < 21 && n < 500) begin tick(1); n++; end
        rst = 1'b1; en = 1'b0;
        tick(1);
        rst = 1'b0;
        checks++; if ({sck, ws, sd, und, busy} !== 5'b00000) begin errors++; $display("FAIL rst_mid_outputs: got %b expected 00000", {sck, ws, sd, und, busy}); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b expected 1", ready); end
        tick(2);
        checks++; if (rx1_q.size() !== base) begin errors++; $display("FAIL rst_mid_partial: got %0d frames expected %0d", rx1_q.size(), base); end
        ub = und1;
        push1(16'hCAFE, 16'hBABE);
        en = 1'b1;
        tick(1);
        en = 1'b0;
        wait_rx1(base + 1);
        wait_idle1();
        checks++; if (rx1_q[base] !== 64'h0000_0000_CAFE_BABE) begin errors++; $display("FAIL rst_mid_restart: got %h expected cafebabe", rx1_q[base]); end
        checks++; if (und1 - ub !== 0) begin errors++; $display("FAIL rst_mid_underrun: got %0d expected 0", und1 - ub); end
    endtask

    task automatic test_extreme();
        logic [63:0] exp_f [16];
        int base, ub, gb;
        for (int i = 0; i < 16; i++) exp_f[i] = {$urandom(), $urandom()};
        base = rx2_q.size(); ub = und2c; gb = gapbad2;
        for (int i = 0; i < 4; i++) push2(exp_f[i][63:32], exp_f[i][31:0]);
        en2 = 1'b1;
        for (int i = 4; i < 16; i++) push2(exp_f[i][63:32], exp_f[i][31:0]);
        wait_rx2(base + 15);
        tick(4);
        en2 = 1'b0;
        wait_rx2(base + 16);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (rx2_q[base+i] !== exp_f[i]) begin errors++; $display("FAIL wide_frame_%0d: got %h expected %h", i, rx2_q[base+i], exp_f[i]); end
        end
        checks++; if (ws2_q[base] !== 64'h0000_0001_FFFF_FFFE) begin errors++; $display("FAIL wide_ws_pattern: got %h expected 00000001fffffffe", ws2_q[base]); end
        checks++; if (und2c - ub !== 0) begin errors++; $display("FAIL wide_underrun: got %0d expected 0", und2c - ub); end
        checks++; if (gapbad2 - gb !== 0) begin errors++; $display("FAIL wide_gap: got %0d irregular periods expected 0", gapbad2 - gb); end
    endtask

    initial begin : main
        tick(1);
        test_reset();
        test_basic_frame();
        test_underrun();
        test_backpressure();
        test_disable_mid_frame();
        test_reset_mid_frame();
        test_extreme();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
